btn_debounce_multi: RTL and testbench

//   Parametrised N-channel button conditioner for the front-panel inputs.

---
 rtl/btn_debounce_multi.sv | 160 ++++++++++++++++
 tb/tb_btn_debounce_multi.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/btn_debounce_multi.sv
// Purpose: N-channel front-panel button conditioner: 2-flop sync, asymmetric debounce, press/release/long/repeat pulses.
// Latency: pin edge to btn_state/pulse is 2 + threshold clocks; long/repeat pulses follow the accepted press by HOLD_CNT (+k*REPEAT_CNT) clocks.
// Backpressure: none; every output is a free-running registered level or one-cycle pulse.
module btn_debounce_multi #(
    parameter int N_CH        = 4,
    parameter int ACTIVE_LOW  = 0,
    parameter int PRESS_CNT   = 500,
    parameter int RELEASE_CNT = 50000,
    parameter int HOLD_CNT    = 0,
    parameter int REPEAT_CNT  = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] btn_state,
    output logic [N_CH-1:0] btn_press,
    output logic [N_CH-1:0] btn_release,
    output logic [N_CH-1:0] long_press,
    output logic [N_CH-1:0] btn_repeat
);

    // Debounce counter is sized for the larger of the two thresholds.
    localparam int MAX_THR = (PRESS_CNT > RELEASE_CNT) ? PRESS_CNT : RELEASE_CNT;
    localparam int CW      = $clog2(MAX_THR + 1);

    // Hold counter must reach HOLD_CNT + REPEAT_CNT; keep at least one bit
    // so the declarations stay legal when the hold feature is disabled.
    localparam int HSUM = HOLD_CNT + REPEAT_CNT;
    localparam int HW   = (HSUM > 0) ? $clog2(HSUM + 1) : 1;

    localparam logic [CW-1:0]   PRESS_LAST   = CW'(PRESS_CNT - 1);
    localparam logic [CW-1:0]   RELEASE_LAST = CW'(RELEASE_CNT - 1);
    localparam logic [HW-1:0]   HOLD_LAST    = HW'(HOLD_CNT - 1);
    localparam logic [HW-1:0]   HOLD_VAL     = HW'(HOLD_CNT);
    localparam logic [HW-1:0]   REP_LAST     = HW'(HSUM - 1);
    localparam logic [N_CH-1:0] INV_MASK     = (ACTIVE_LOW != 0) ? '1 : '0;

    logic [N_CH-1:0] sync1_q;
    logic [N_CH-1:0] sync2_q;
    logic [N_CH-1:0] s;

    // Two-flop synchroniser for the raw asynchronous pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_in;
            sync2_q <= sync1_q;
        end
    end

    // Normalise polarity so that 1 always means "pressed" downstream.
    assign s = sync2_q ^ INV_MASK;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch

        logic [CW-1:0] cnt_q;
        logic [CW-1:0] cnt_d;
        logic          state_q;
        logic          state_d;
        logic          press_q;
        logic          press_d;
        logic          release_q;
        logic          release_d;

        // Count consecutive samples that disagree with the accepted level;
        // any agreeing sample restarts the count, so only a clean run of
        // exactly THR samples flips the level.
        always_comb begin
            cnt_d     = cnt_q;
            state_d   = state_q;
            press_d   = 1'b0;
            release_d = 1'b0;
            if (s[i] == state_q) begin
                cnt_d = '0;
            end else if (cnt_q == (state_q ? RELEASE_LAST : PRESS_LAST)) begin
                cnt_d     = '0;
                state_d   = ~state_q;
                press_d   = ~state_q;
                release_d = state_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        // Debounce state, counter and edge pulses.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q     <= '0;
                state_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                cnt_q     <= cnt_d;
                state_q   <= state_d;
                press_q   <= press_d;
                release_q <= release_d;
            end
        end

        assign btn_state[i]   = state_q;
        assign btn_press[i]   = press_q;
        assign btn_release[i] = release_q;

        if (HOLD_CNT > 0) begin : g_hold

            logic [HW-1:0] hold_q;
            logic [HW-1:0] hold_d;
            logic          long_q;
            logic          long_d;
            logic          rep_q;
            logic          rep_d;

            // Hold timer: zero while released and on the accept/release
            // cycles (state_d != state_q), so the release cycle can never
            // carry a long or repeat pulse. After the long pulse the counter
            // either cycles HOLD..HOLD+REPEAT for repeats or parks at HOLD.
            always_comb begin
                hold_d = hold_q;
                long_d = 1'b0;
                rep_d  = 1'b0;
                if (!state_q || (state_d != state_q)) begin
                    hold_d = '0;
                end else if ((REPEAT_CNT > 0) && (hold_q == REP_LAST)) begin
                    hold_d = HOLD_VAL;
                    rep_d  = 1'b1;
                end else if (hold_q == HOLD_LAST) begin
                    hold_d = HOLD_VAL;
                    long_d = 1'b1;
                end else if ((REPEAT_CNT > 0) || (hold_q != HOLD_VAL)) begin
                    hold_d = hold_q + HW'(1);
                end
            end

            // Hold counter and long/repeat pulse registers.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    hold_q <= '0;
                    long_q <= 1'b0;
                    rep_q  <= 1'b0;
                end else begin
                    hold_q <= hold_d;
                    long_q <= long_d;
                    rep_q  <= rep_d;
                end
            end

            assign long_press[i] = long_q;
            assign btn_repeat[i] = rep_q;

        end else begin : g_no_hold

            assign long_press[i] = 1'b0;
            assign btn_repeat[i] = 1'b0;

        end
    end

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Purpose: directed self-checking bench for btn_debounce_multi (active-high and active-low instances).
// Latency: expectations are hand-timed in clocks from each pin change.
// Backpressure: not applicable.
module tb_btn_debounce_multi;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] btn_a, btn_b;
    logic [1:0] st_a, pr_a, rl_a, lp_a, rp_a;
    logic [1:0] st_b, pr_b, rl_b, lp_b, rp_b;
    logic [1:0] acc;
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    btn_debounce_multi #(
        .N_CH(2), .ACTIVE_LOW(0), .PRESS_CNT(4), .RELEASE_CNT(8),
        .HOLD_CNT(20), .REPEAT_CNT(5)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .btn_in(btn_a),
        .btn_state(st_a), .btn_press(pr_a), .btn_release(rl_a),
        .long_press(lp_a), .btn_repeat(rp_a)
    );

    btn_debounce_multi #(
        .N_CH(2), .ACTIVE_LOW(1), .PRESS_CNT(4), .RELEASE_CNT(8),
        .HOLD_CNT(20), .REPEAT_CNT(5)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .btn_in(btn_b),
        .btn_state(st_b), .btn_press(pr_b), .btn_release(rl_b),
        .long_press(lp_b), .btn_repeat(rp_b)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // 1: reset with both pins pressed, then acceptance after 2+4 clocks
        rst_n = 1'b0;
        btn_a = 2'b11;
        btn_b = 2'b11;
        tick(3);
        chk("rst_state", 32'(st_a), 32'h0);
        chk("rst_press", 32'(pr_a), 32'h0);
        chk("rst_release", 32'(rl_a), 32'h0);
        chk("rst_long", 32'(lp_a), 32'h0);
        chk("rst_repeat", 32'(rp_a), 32'h0);
        chk("rst_state_b", 32'(st_b), 32'h0);
        rst_n = 1'b1;
        tick(5);
        chk("t1_state_early", 32'(st_a), 32'h0);
        chk("t1_press_early", 32'(pr_a), 32'h0);
        tick(1);
        chk("t1_state", 32'(st_a), 32'h3);
        chk("t1_press", 32'(pr_a), 32'h3);
        tick(1);
        chk("t1_press_once", 32'(pr_a), 32'h0);
        chk("t1_state_hold", 32'(st_a), 32'h3);
        chk("t1_b_idle", 32'(st_b | pr_b), 32'h0);
        btn_a = 2'b00;
        tick(9);
        chk("t1_rel_early", 32'(rl_a), 32'h0);
        tick(1);
        chk("t1_release", 32'(rl_a), 32'h3);
        chk("t1_rel_state", 32'(st_a), 32'h0);
        tick(1);
        chk("t1_release_once", 32'(rl_a), 32'h0);

        // 2: ch0 bounces in 2-cycle runs, then settles high
        acc = 2'b00;
        for (int k = 0; k < 4; k++) begin
            btn_a[0] = (k % 2 == 0);
            for (int j = 0; j < 2; j++) begin
                tick(1);
                acc = acc | pr_a | st_a;
            end
        end
        btn_a[0] = 1'b1;
        tick(1);
        acc = acc | pr_a | st_a;
        chk("t2_no_bounce_pulse", 32'(acc), 32'h0);
        tick(4);
        chk("t2_state_early", 32'(st_a), 32'h0);
        tick(1);
        chk("t2_press", 32'(pr_a), 32'h1);
        chk("t2_state", 32'(st_a), 32'h1);

        // 3: release 10 clocks later; release coincides with the would-be
        // long press, which must be suppressed
        tick(10);
        btn_a[0] = 1'b0;
        tick(9);
        chk("t3_rel_early", 32'(rl_a), 32'h0);
        chk("t3_state_early", 32'(st_a), 32'h1);
        tick(1);
        chk("t3_release", 32'(rl_a), 32'h1);
        chk("t3_no_long_in_rel", 32'(lp_a), 32'h0);
        chk("t3_state", 32'(st_a), 32'h0);
        tick(1);
        chk("t3_no_long_after", 32'(lp_a), 32'h0);
        btn_a[0] = 1'b1;
        tick(6);
        chk("t3_repress", 32'(pr_a), 32'h1);
        btn_a[0] = 1'b0;
        tick(7);
        btn_a[0] = 1'b1;
        acc = 2'b00;
        for (int k = 0; k < 14; k++) begin
            tick(1);
            acc = acc | rl_a;
        end
        chk("t3_glitch_no_rel", 32'(acc), 32'h0);
        chk("t3_glitch_state", 32'(st_a), 32'h1);
        btn_a[0] = 1'b0;
        tick(10);
        chk("t3_final_rel", 32'(st_a), 32'h0);

        // 4: ch1 long press and auto-repeat, then release
        btn_a[1] = 1'b1;
        tick(6);
        chk("t4_press", 32'(pr_a), 32'h2);
        for (int k = 1; k <= 60; k++) begin
            tick(1);
            chk($sformatf("t4_long_k%0d", k), 32'(lp_a), (k == 20) ? 32'h2 : 32'h0);
            chk($sformatf("t4_rep_k%0d", k), 32'(rp_a),
                ((k >= 25) && (k < 49) && (k % 5 == 0)) ? 32'h2 : 32'h0);
            chk($sformatf("t4_rel_k%0d", k), 32'(rl_a), (k == 49) ? 32'h2 : 32'h0);
            if (k == 39) btn_a[1] = 1'b0;
        end

        // 5: async reset in the middle of a hold, no clock edge needed
        btn_a[1] = 1'b1;
        tick(6);
        chk("t5_press", 32'(pr_a), 32'h2);
        tick(15);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_async_state", 32'(st_a), 32'h0);
        chk("t5_async_pulses", 32'(pr_a | rl_a | lp_a | rp_a), 32'h0);
        tick(2);
        rst_n = 1'b1;
        tick(5);
        chk("t5_repress_early", 32'(st_a), 32'h0);
        tick(1);
        chk("t5_repress_state", 32'(st_a), 32'h2);
        chk("t5_repress_pulse", 32'(pr_a), 32'h2);
        btn_a[1] = 1'b0;
        tick(10);
        chk("t5_final_rel", 32'(st_a), 32'h0);

        // 6: active-low instance, simultaneous press then independent release
        btn_b = 2'b00;
        tick(5);
        chk("t6_state_early", 32'(st_b), 32'h0);
        tick(1);
        chk("t6_state", 32'(st_b), 32'h3);
        chk("t6_press", 32'(pr_b), 32'h3);
        btn_b = 2'b01;
        tick(9);
        chk("t6_rel_early", 32'(rl_b), 32'h0);
        tick(1);
        chk("t6_release", 32'(rl_b), 32'h1);
        chk("t6_state_after", 32'(st_b), 32'h2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
